// File: rtl/rc4_pkg.sv
// Shared constants, byte type and controller state encoding for the
// RC4 host-side key loader and keystream XOR datapath.
package rc4_pkg;

    localparam int KEY_SIZE = 7;
    localparam int BYTE_W   = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FEED  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream FIFO: synchronous flush, push accepted while full only when
// the head is popped in the same cycle.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [BYTE_W-1:0] i_din,
    output logic [BYTE_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = idx_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    byte_t       r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
        end
    end

    // When full, the write slot is the head being popped; head is read first.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/rc4_stream_xor.sv
// Host companion to the rc4 generator: loads and replays the password,
// then XORs the buffered keystream into a valid/ready byte stream.
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int KEY_SIZE   = rc4_pkg::KEY_SIZE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clock0,
    input  logic              rst,
    input  logic              rekey,
    input  logic              key_valid,
    input  logic [BYTE_W-1:0] key_data,
    output logic              key_ready,
    output logic              rc4_rst,
    output logic [BYTE_W-1:0] rc4_password,
    input  logic              ks_valid,
    input  logic [BYTE_W-1:0] ks_byte,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [BYTE_W-1:0] m_data,
    input  logic              m_ready,
    output logic              keyed,
    output logic              overrun
);

    localparam int CW = idx_w(KEY_SIZE);
    localparam logic [CW-1:0] LAST    = CW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    byte_t         r_key [KEY_SIZE];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_feed_idx;
    logic          r_rc4_rst;
    logic          r_m_valid;
    byte_t         r_m_data;
    logic          r_overrun;

    logic  w_clear;
    logic  w_key_acc;
    logic  w_key_last;
    logic  w_push;
    logic  w_pop;
    logic  w_full;
    logic  w_empty;
    logic  w_overflow;
    byte_t w_head;

    assign w_clear    = rst || rekey;
    assign key_ready  = (r_state == ST_LOAD);
    assign w_key_acc  = key_valid && key_ready;
    assign w_key_last = w_key_acc && (r_cnt == LAST);

    assign keyed      = (r_state == ST_RUN);
    assign s_ready    = keyed && !w_empty && (!r_m_valid || m_ready);
    assign w_pop      = s_valid && s_ready;
    assign w_push     = keyed && ks_valid;
    assign w_overflow = w_push && w_full && !w_pop;

    assign rc4_password = (r_state == ST_FEED) ? r_key[r_feed_idx] : '0;
    assign rc4_rst      = r_rc4_rst;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign overrun      = r_overrun;

    always_ff @(posedge clock0) begin
        if (w_clear) r_state <= ST_LOAD;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOAD:  if (w_key_last) w_state_nxt = ST_FEED;
            ST_FEED:  if (r_feed_idx == LAST) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_overflow) w_state_nxt = ST_ERROR;
            ST_ERROR: w_state_nxt = ST_ERROR;
        endcase
    end

    always_ff @(posedge clock0) begin
        if (w_key_acc && !w_clear) r_key[r_cnt] <= key_data;
    end

    // rc4_rst falls with the last key byte; the generator reads key[n]
    // on the (n+1)th edge after that, tracking feed_idx one-for-one.
    always_ff @(posedge clock0) begin
        if (w_clear) begin
            r_cnt      <= '0;
            r_feed_idx <= '0;
            r_rc4_rst  <= 1'b1;
        end else begin
            if (w_key_acc) r_cnt <= r_cnt + CNT_ONE;
            if (w_key_last) begin
                r_cnt      <= '0;
                r_feed_idx <= '0;
                r_rc4_rst  <= 1'b0;
            end
            if (r_state == ST_FEED) r_feed_idx <= r_feed_idx + CNT_ONE;
        end
    end

    always_ff @(posedge clock0) begin
        if (w_clear) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_pop) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_data ^ w_head;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_overflow) r_overrun <= 1'b1;
        end
    end

    rc4_ks_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock0),
        .i_flush (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (ks_byte),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: key load/replay, XOR datapath, FIFO limits,
// overrun, rekey and a software RC4 keystream driven through the block.
`timescale 1ns/1ps
module tb_rc4_stream_xor;

    localparam int KS    = 7;
    localparam int DEPTH = 16;

    logic       clock0 = 1'b0;
    logic       rst = 1'b1;
    logic       rekey = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_ready;
    logic       rc4_rst;
    logic [7:0] rc4_password;
    logic       ks_valid = 1'b0;
    logic [7:0] ks_byte = 8'h00;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       keyed;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock0 = ~clock0;

    rc4_stream_xor #(
        .KEY_SIZE   (KS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock0       (clock0),
        .rst          (rst),
        .rekey        (rekey),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_ready    (key_ready),
        .rc4_rst      (rc4_rst),
        .rc4_password (rc4_password),
        .ks_valid     (ks_valid),
        .ks_byte      (ks_byte),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .keyed        (keyed),
        .overrun      (overrun)
    );

    task automatic rc4_model(input logic [7:0] key [KS],
                             output logic [7:0] out [64]);
        int s [256];
        int i, j, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(key[n % KS])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int n = 0; n < 1600; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (n >= 1536) out[n - 1536] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clock0);
        #1;
        n_vec++;
        if ({key_ready, rc4_rst, keyed, overrun, m_valid, s_ready,
             rc4_password, m_data} !== {6'b110000, 8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL reset got %b/%h/%h want 110000/00/00",
                     {key_ready, rc4_rst, keyed, overrun, m_valid, s_ready},
                     rc4_password, m_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_key_load(input logic [7:0] k [KS], input int gap_after);
        for (int b = 0; b < KS; b++) begin
            if (b == gap_after) begin
                repeat (2) begin
                    @(negedge clock0);
                    key_valid = 1'b0;
                    #1;
                    n_vec++;
                    if ({key_ready, rc4_rst} !== 2'b11) begin
                        n_err++;
                        $display("FAIL load_gap got %b want 11", {key_ready, rc4_rst});
                    end
                end
            end
            @(negedge clock0);
            key_valid = 1'b1;
            key_data  = k[b];
            #1;
            n_vec++;
            if ({key_ready, rc4_rst, keyed} !== 3'b110) begin
                n_err++;
                $display("FAIL load_ready byte %0d got %b want 110", b,
                         {key_ready, rc4_rst, keyed});
            end
        end
        @(negedge clock0);
        key_valid = 1'b0;
        key_data  = 8'h00;
        #1;
        n_vec++;
        if ({rc4_rst, key_ready, keyed, rc4_password} !== {3'b000, k[0]}) begin
            n_err++;
            $display("FAIL feed_start got %b/%h want 000/%h",
                     {rc4_rst, key_ready, keyed}, rc4_password, k[0]);
        end
        for (int n = 1; n < KS; n++) begin
            @(negedge clock0);
            #1;
            n_vec++;
            if ({keyed, rc4_password} !== {1'b0, k[n]}) begin
                n_err++;
                $display("FAIL feed_byte %0d got %b/%h want 0/%h", n,
                         keyed, rc4_password, k[n]);
            end
        end
        @(negedge clock0);
        #1;
        n_vec++;
        if ({keyed, rc4_rst, key_ready, rc4_password} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL keyed got %b/%h want 100/00",
                     {keyed, rc4_rst, key_ready}, rc4_password);
        end
    endtask

    task automatic test_single_xor();
        @(negedge clock0);
        m_ready = 1'b1; ks_valid = 1'b1; ks_byte = 8'hA5;
        #1;
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL xor_empty_ready got %b want 0", s_ready);
        end
        @(negedge clock0);
        ks_valid = 1'b0; s_valid = 1'b1; s_data = 8'h5A;
        #1;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL xor_ready got %b want 1", s_ready);
        end
        @(negedge clock0);
        s_valid = 1'b0;
        #1;
        n_vec++;
        if ({m_valid, m_data, s_ready} !== {1'b1, 8'hFF, 1'b0}) begin
            n_err++;
            $display("FAIL xor_out got %b/%h/%b want 1/ff/0", m_valid, m_data, s_ready);
        end
        @(negedge clock0);
        #1;
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL xor_clear got %b want 0", m_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] q [$];
        logic [7:0] b, d, e;
        m_ready = 1'b1; s_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock0);
            ks_valid = 1'b1; b = 8'($urandom); ks_byte = b; q.push_back(b);
        end
        @(negedge clock0);
        b = 8'($urandom); ks_byte = b;
        d = 8'($urandom); s_valid = 1'b1; s_data = d;
        #1;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_ready got %b want 1", s_ready);
        end
        e = d ^ q.pop_front();
        q.push_back(b);
        @(negedge clock0);
        ks_valid = 1'b0; s_valid = 1'b0;
        #1;
        n_vec++;
        if ({m_valid, m_data, overrun, keyed} !== {1'b1, e, 2'b01}) begin
            n_err++;
            $display("FAIL full_pushpop got %b/%h/%b want 1/%h/01",
                     m_valid, m_data, {overrun, keyed}, e);
        end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock0);
            d = 8'($urandom); s_valid = 1'b1; s_data = d;
            #1;
            n_vec++;
            if (s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL drain_ready %0d got %b want 1", i, s_ready);
            end
            e = d ^ q.pop_front();
            @(negedge clock0);
            s_valid = 1'b0;
            #1;
            n_vec++;
            if ({m_valid, m_data} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL drain_data %0d got %b/%h want 1/%h", i, m_valid, m_data, e);
            end
        end
        @(negedge clock0);
        s_valid = 1'b1;
        #1;
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty got %b want 0", s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [7:0] q [$];
        logic       mv = 1'b0;
        logic [7:0] md = 8'h00;
        logic       sr, acc;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock0);
            n_vec++;
            if (m_valid !== mv || (mv && m_data !== md)) begin
                n_err++;
                $display("FAIL rnd_out cyc %0d got %b/%h want %b/%h", c, m_valid, m_data, mv, md);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            sr  = (q.size() > 0) && (!mv || m_ready);
            acc = s_valid && sr;
            ks_valid = 1'($urandom_range(0, 1)) && (q.size() < DEPTH || acc);
            ks_byte  = 8'($urandom);
            #1;
            n_vec++;
            if (s_ready !== sr) begin
                n_err++;
                $display("FAIL rnd_ready cyc %0d got %b want %b", c, s_ready, sr);
            end
            if (acc) begin
                md = s_data ^ q.pop_front();
                mv = 1'b1;
            end else if (m_ready) begin
                mv = 1'b0;
            end
            if (ks_valid) q.push_back(ks_byte);
        end
        @(negedge clock0);
        ks_valid = 1'b0; s_valid = 1'b0;
        #1;
        n_vec++;
        if ({overrun, keyed} !== 2'b01) begin
            n_err++;
            $display("FAIL rnd_state got %b want 01", {overrun, keyed});
        end
        // empty the FIFO so later scenarios start clean
        m_ready = 1'b1;
        while (q.size() > 0) begin
            @(negedge clock0);
            s_valid = 1'b1;
            void'(q.pop_front());
        end
        @(negedge clock0);
        s_valid = 1'b0;
        @(negedge clock0);
    endtask

    task automatic test_rekey();
        logic [7:0] k2 [KS];
        @(negedge clock0);
        m_ready = 1'b0; s_valid = 1'b0;
        ks_valid = 1'b1; ks_byte = 8'($urandom);
        @(negedge clock0);
        ks_byte = 8'($urandom);
        @(negedge clock0);
        ks_valid = 1'b0; s_valid = 1'b1; s_data = 8'($urandom);
        #1;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rekey_pre_ready got %b want 1", s_ready);
        end
        @(negedge clock0);
        s_valid = 1'b0;
        #1;
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rekey_pending got %b want 1", m_valid);
        end
        rekey = 1'b1; key_valid = 1'b1; key_data = 8'hEE;
        @(negedge clock0);
        rekey = 1'b0; key_valid = 1'b0;
        #1;
        n_vec++;
        if ({keyed, rc4_rst, m_valid, overrun, key_ready, m_data} !== {5'b01001, 8'h00}) begin
            n_err++;
            $display("FAIL rekey_state got %b/%h want 01001/00",
                     {keyed, rc4_rst, m_valid, overrun, key_ready}, m_data);
        end
        for (int i = 0; i < KS; i++) k2[i] = 8'($urandom);
        test_key_load(k2, KS);
        @(negedge clock0);
        m_ready = 1'b1; s_valid = 1'b1;
        #1;
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rekey_flush got %b want 0", s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] d, e, b;
        @(negedge clock0);
        m_ready = 1'b0;
        ks_valid = 1'b1; b = 8'($urandom); ks_byte = b;
        @(negedge clock0);
        ks_valid = 1'b0; d = 8'($urandom); s_valid = 1'b1; s_data = d;
        e = d ^ b;
        @(negedge clock0);
        #1;
        n_vec++;
        if ({m_valid, m_data, s_ready} !== {1'b1, e, 1'b0}) begin
            n_err++;
            $display("FAIL ovr_pending got %b/%h/%b want 1/%h/0", m_valid, m_data, s_ready, e);
        end
        for (int i = 1; i <= DEPTH + 1; i++) begin
            ks_valid = 1'b1; ks_byte = 8'($urandom);
            @(negedge clock0);
            #1;
            n_vec++;
            if ({overrun, s_ready} !== {(i == DEPTH + 1), 1'b0}) begin
                n_err++;
                $display("FAIL ovr_push %0d got %b want %b", i,
                         {overrun, s_ready}, {(i == DEPTH + 1), 1'b0});
            end
        end
        n_vec++;
        if ({keyed, m_valid, m_data} !== {2'b01, e}) begin
            n_err++;
            $display("FAIL ovr_error got %b/%h want 01/%h", {keyed, m_valid}, m_data, e);
        end
        m_ready = 1'b1;
        @(negedge clock0);
        #1;
        n_vec++;
        if ({m_valid, s_ready, overrun} !== 3'b001) begin
            n_err++;
            $display("FAIL ovr_drain got %b want 001", {m_valid, s_ready, overrun});
        end
        ks_valid = 1'b0; s_valid = 1'b0; rekey = 1'b1;
        @(negedge clock0);
        rekey = 1'b0;
        #1;
        n_vec++;
        if ({overrun, rc4_rst, key_ready} !== 3'b011) begin
            n_err++;
            $display("FAIL ovr_rekey got %b want 011", {overrun, rc4_rst, key_ready});
        end
    endtask

    task automatic test_rekey_feed();
        for (int b = 0; b < KS; b++) begin
            @(negedge clock0);
            key_valid = 1'b1; key_data = 8'($urandom);
        end
        @(negedge clock0);
        key_valid = 1'b0;
        #1;
        n_vec++;
        if (rc4_rst !== 1'b0) begin
            n_err++;
            $display("FAIL feed_rst_low got %b want 0", rc4_rst);
        end
        repeat (2) @(negedge clock0);
        rekey = 1'b1;
        @(negedge clock0);
        rekey = 1'b0;
        #1;
        n_vec++;
        if ({rc4_rst, key_ready, keyed, rc4_password} !== {3'b110, 8'h00}) begin
            n_err++;
            $display("FAIL feed_rekey got %b/%h want 110/00",
                     {rc4_rst, key_ready, keyed}, rc4_password);
        end
    endtask

    task automatic test_rc4_stream();
        logic [7:0] key [KS];
        logic [7:0] ks [64];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        key = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74, 8'h21};
        rc4_model(key, ks);
        test_key_load(key, KS);
        m_ready = 1'b1;
        while (got < 64 && cyc < 300) begin
            @(negedge clock0);
            if (m_valid) begin
                n_vec++;
                if (m_data !== ks[got]) begin
                    n_err++;
                    $display("FAIL rc4_byte %0d got %h want %h", got + 1536, m_data, ks[got]);
                end
                got++;
            end
            ks_valid = (sent < 64);
            if (sent < 64) begin
                ks_byte = ks[sent];
                sent++;
            end
            s_valid = 1'b1; s_data = 8'h00;
            cyc++;
        end
        ks_valid = 1'b0; s_valid = 1'b0;
        n_vec++;
        if (got != 64) begin
            n_err++;
            $display("FAIL rc4_timeout got %0d bytes want 64", got);
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rc4_overrun got %b want 0", overrun);
        end
    endtask

    initial begin
        logic [7:0] k1 [KS];
        k1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        test_reset();
        test_key_load(k1, 3);
        test_single_xor();
        test_full_push_pop();
        test_random_stream();
        test_rekey();
        test_overrun();
        test_rekey_feed();
        test_rc4_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
- Host-side companion to the `rc4` keystream generator. Drives the generator's key-read sequence: holds `rc4` in reset, collects a `KEY_SIZE`-byte password over a handshake, then releases reset and presents one password byte per clock.
- In RUN, buffers the keystream (`K`, qualified by `output_ready`) in a small FIFO and XORs it with a valid/ready data stream. This forms the encrypt/decrypt datapath.
- `rc4` cannot stall, so loss of a keystream byte is detected and reported as a sticky overrun.

Parameters:
- KEY_SIZE, 7, password length in bytes; must equal the generator's key size.
- FIFO_DEPTH, 16, keystream FIFO entries; power of two, ≥ 2.

Ports:
- clock0  in  1  clock
- rst  in  1  synchronous, active-high reset
- rekey  in  1  pulse: abort and restart key load
- key_valid  in  1  password byte valid
- key_data  in  8  password byte
- key_ready  out  1  block accepts password byte
- rc4_rst  out  1  reset to generator (registered)
- rc4_password  out  8  byte to generator `password_input`
- ks_valid  in  1  generator `output_ready`
- ks_byte  in  8  generator `K`
- s_valid  in  1  input data valid
- s_data  in  8  plaintext/ciphertext in
- s_ready  out  1  input accepted
- m_valid  out  1  output valid
- m_data  out  8  s_data XOR keystream
- m_ready  in  1  downstream accepts
- keyed  out  1  state == RUN
- overrun  out  1  sticky keystream loss

Behaviour:
- States: LOAD, FEED, RUN, ERROR.
- Reset values: state LOAD, rc4_rst 1, rc4_password 0, key count 0, feed_idx 0, FIFO empty, m_valid 0, m_data 0, overrun 0.
- Priority: rst > rekey > all other events.
- rekey, any state: same effect as rst. Key bytes are discarded, FIFO is flushed, a pending m_valid is dropped, overrun is cleared. rekey beats a same-cycle key_valid.

LOAD:
- key_ready = 1; rc4_rst = 1; ks_valid is ignored.
- Each key_valid&&key_ready stores key_data at key[cnt] and increments cnt.
- Gaps in key_valid are allowed.
- On acceptance of byte KEY_SIZE-1: go to FEED, clear feed_idx, register rc4_rst to 0.

FEED:
- key_ready = 0; rc4_password = key[feed_idx] (combinational mux from key registers).
- feed_idx increments every cycle. The generator samples key[n] on the (n+1)th edge after rc4_rst falls.
- When feed_idx == KEY_SIZE-1, go to RUN next cycle. In RUN, rc4_password = 0.

RUN, keystream FIFO:
- Push when ks_valid.
- Pop when an input byte is accepted.
- Push and pop in the same cycle while full is legal and is not an overrun.
- Push while full with no pop: byte lost, overrun set to 1, go to ERROR.

RUN, datapath:
- s_ready = (state==RUN) && !fifo_empty && (!m_valid || m_ready).
- On s_valid&&s_ready: m_data <= s_data ^ fifo_head, m_valid <= 1, pop. Latency is 1 cycle.
- m_valid clears on m_ready when no new byte is accepted.
- Full throughput is 1 byte/cycle. Sustained m_ready = 0 inevitably overruns, because the generator runs at 1 byte/cycle.

ERROR:
- s_ready = 0; an already-pending m_valid output still drains; FIFO is frozen.
- Exit only via rst or rekey.

Other rules:
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, with wrap-around on the MSB.
- Reset or rekey in mid-FEED re-asserts rc4_rst on the next edge. The generator then re-reads the key from the start.

Decomposition:
- Shared package rc4_pkg holds:
  - KEY_SIZE constant, shared with `rc4`
  - state encoding (LOAD=2'd0, FEED=2'd1, RUN=2'd2, ERROR=2'd3)
  - byte width constant
- One sub-module, rc4_ks_fifo: synchronous FIFO with push/pop/full/empty/flush and same-cycle push+pop when full.

Test Plan:
1. Reset, then key bytes 01..07 with a 2-cycle gap after byte 3 → key_ready high only in LOAD. rc4_rst falls 1 cycle after byte 07 is accepted. rc4_password reads 01,02,…,07 on the next 7 edges. keyed = 1 one cycle later.
2. RUN, bench ks_byte 0xA5 (ks_valid for 1 cycle), then s_data 0x5A → m_valid next cycle with m_data 0xFF. FIFO is empty afterwards and s_ready = 0.
3. RUN, ks_valid continuous with m_ready = 0 → FIFO reaches 16 entries, overrun = 1 on the 17th push-without-pop. s_ready = 0. The pending m_data drains when m_ready = 1.
4. FIFO full, ks_valid and a s_valid accept in the same cycle → no overrun, occupancy stays 16, output equals the head XOR.
5. rekey asserted mid-RUN together with key_valid → next cycle state LOAD, rc4_rst 1, m_valid 0, overrun 0, FIFO empty, that key byte is not stored.
6. Integration with `rc4`, key "Secret!" (0x53,0x65,0x63,0x72,0x65,0x74,0x21), 64 bytes of 0x00 → m_data equals the software RC4 model's bytes 1536..1599; no overrun with m_ready = 1.
